mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_stage_data_memory.sv | 33 +++
 rtl/mem_stage.sv | 128 ++++++++++++
 tb/tb_mem_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: memory access width encodings, default data-memory
// depth and the alignment rule used by both the decoder and the MEM stage.
package mem_stage_pkg;

    localparam int DEPTH_DEFAULT = 256;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b11;

    // Encoding 2'b10 is illegal and always counts as misaligned.
    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic bad;
        case (width)
            WIDTH_BYTE: bad = 1'b0;
            WIDTH_HALF: bad = addr_lo[0];
            WIDTH_WORD: bad = |addr_lo;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Synchronous DEPTH x 32 data RAM: per-byte write enables and a registered,
// read-first output that holds while the read enable is low.
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rd_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH] = '{default: '0};
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (i_we[k]) begin
                r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
            end
        end
        if (i_rd_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-lane stores, extended loads, alignment checking and
// the MEM/WB register, with the data RAM as the only sub-module.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inAluResult,
    input  logic [31:0] inWriteData,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic [1:0]  inMemWidth,
    input  logic        inMemUnsigned,
    input  logic        inRegWrite,
    input  logic        inMemToReg,
    input  logic [4:0]  inWriteReg,
    input  logic        stall,
    output logic [31:0] outReadData,
    output logic [31:0] outAluResult,
    output logic [4:0]  outWriteReg,
    output logic        outRegWrite,
    output logic        outMemToReg,
    output logic        outAddrError
);

    localparam int AW = $clog2(DEPTH);

    function automatic logic [3:0] byte_enable(input logic [1:0] width, input logic [1:0] lane);
        case (width)
            WIDTH_BYTE: return 4'b0001 << lane;
            WIDTH_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] width, input logic [31:0] data);
        case (width)
            WIDTH_BYTE: return {4{data[7:0]}};
            WIDTH_HALF: return {2{data[15:0]}};
            default:    return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] width, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (width)
            WIDTH_BYTE: return uns ? {24'b0, b} : 32'(b);
            WIDTH_HALF: return uns ? {16'b0, h} : 32'(h);
            default:    return word;
        endcase
    endfunction

    logic          w_misalign;
    logic          w_err;
    logic          w_load;
    logic          w_store;
    logic          w_rd_en;
    logic [3:0]    w_we;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rdata;

    assign w_misalign = misaligned(inMemWidth, inAluResult[1:0]);
    assign w_err      = (inMemRead | inMemWrite) & w_misalign;
    assign w_load     = inMemRead & ~inMemWrite & ~w_misalign;
    assign w_store    = inMemWrite & ~w_misalign & ~stall & ~reset;
    assign w_we       = w_store ? byte_enable(inMemWidth, inAluResult[1:0]) : 4'b0000;
    assign w_wdata    = store_lanes(inMemWidth, inWriteData);
    // Freezing the RAM read register keeps outReadData stable across a stall.
    assign w_rd_en    = ~stall;

    data_memory #(.DEPTH(DEPTH)) u_dmem (
        .i_clk   (clk),
        .i_rd_en (w_rd_en),
        .i_we    (w_we),
        .i_addr  (inAluResult[AW+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    logic        r_load_vld_p1;
    logic [1:0]  r_lane_p1;
    logic [1:0]  r_width_p1;
    logic        r_unsigned_p1;
    logic [31:0] r_alu_p1;
    logic [4:0]  r_wreg_p1;
    logic        r_regwrite_p1;
    logic        r_memtoreg_p1;
    logic        r_err_p1;

    // MEM -> WB boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_vld_p1 <= 1'b0;
            r_lane_p1     <= '0;
            r_width_p1    <= '0;
            r_unsigned_p1 <= 1'b0;
            r_alu_p1      <= '0;
            r_wreg_p1     <= '0;
            r_regwrite_p1 <= 1'b0;
            r_memtoreg_p1 <= 1'b0;
            r_err_p1      <= 1'b0;
        end else if (!stall) begin
            r_load_vld_p1 <= w_load;
            r_lane_p1     <= inAluResult[1:0];
            r_width_p1    <= inMemWidth;
            r_unsigned_p1 <= inMemUnsigned;
            r_alu_p1      <= inAluResult;
            r_wreg_p1     <= inWriteReg;
            r_regwrite_p1 <= inRegWrite & ~w_err;
            r_memtoreg_p1 <= inMemToReg;
            r_err_p1      <= w_err;
        end
    end

    assign outReadData  = r_load_vld_p1 ? load_extend(w_rdata, r_lane_p1, r_width_p1, r_unsigned_p1) : '0;
    assign outAluResult = r_alu_p1;
    assign outWriteReg  = r_wreg_p1;
    assign outRegWrite  = r_regwrite_p1;
    assign outMemToReg  = r_memtoreg_p1;
    assign outAddrError = r_err_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-addressed reference memory predicts each
// MEM/WB result, which is queued on drive and compared one edge later.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inAluResult, inWriteData;
    logic        inMemRead, inMemWrite, inMemUnsigned, inRegWrite, inMemToReg, stall;
    logic [1:0]  inMemWidth;
    logic [4:0]  inWriteReg;
    logic [31:0] outReadData, outAluResult;
    logic [4:0]  outWriteReg;
    logic        outRegWrite, outMemToReg, outAddrError;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(256)) dut (
        .clk(clk), .reset(reset),
        .inAluResult(inAluResult), .inWriteData(inWriteData),
        .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .inMemWidth(inMemWidth), .inMemUnsigned(inMemUnsigned),
        .inRegWrite(inRegWrite), .inMemToReg(inMemToReg), .inWriteReg(inWriteReg),
        .stall(stall),
        .outReadData(outReadData), .outAluResult(outAluResult), .outWriteReg(outWriteReg),
        .outRegWrite(outRegWrite), .outMemToReg(outMemToReg), .outAddrError(outAddrError)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        regw;
        logic        m2r;
        logic        err;
    } exp_t;

    exp_t       sbq[$];
    exp_t       last_exp;
    logic [7:0] ref_mem [1024];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         tx    = 0;

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b11, ILL = 2'b10;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] w, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic regw, input logic stl, input logic rst);
        exp_t        e;
        int          size;
        int          base;
        logic        mis;
        logic [31:0] v;
        logic [31:0] m;
        @(negedge clk);
        reset = rst; stall = stl;
        inMemRead = rd; inMemWrite = wr; inMemWidth = w; inMemUnsigned = uns;
        inAluResult = addr; inWriteData = data; inRegWrite = regw;
        inWriteReg = 5'(tx); inMemToReg = tx[0];
        tx++;
        size = (w == B) ? 1 : (w == H) ? 2 : (w == W) ? 4 : 0;
        if (size == 0) mis = 1'b1;
        else           mis = (addr % size) != 0;
        base = int'(addr & 32'h3FF);
        if (rst) begin
            e = '{default: '0};
        end else if (stl) begin
            e = last_exp;
        end else begin
            e.err   = (rd | wr) & mis;
            e.regw  = regw & ~e.err;
            e.alu   = addr;
            e.wreg  = inWriteReg;
            e.m2r   = inMemToReg;
            e.rdata = '0;
            if (wr && !mis) begin
                for (int i = 0; i < size; i++) ref_mem[(base + i) & 1023] = data[8*i +: 8];
            end else if (rd && !mis) begin
                v = '0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[(base + i) & 1023];
                if (!uns && size < 4 && v[8*size-1]) begin
                    m = (32'h1 << (8*size)) - 32'h1;
                    v = v | ~m;
                end
                e.rdata = v;
            end
        end
        sbq.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("rdata", outReadData, e.rdata);
        check("alu", outAluResult, e.alu);
        check("wreg", 32'(outWriteReg), 32'(e.wreg));
        check("regw", 32'(outRegWrite), 32'(e.regw));
        check("m2r", 32'(outMemToReg), 32'(e.m2r));
        check("aerr", 32'(outAddrError), 32'(e.err));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        last_exp = '{default: '0};
        reset = 1'b1; stall = 1'b0;
        inMemRead = 0; inMemWrite = 0; inMemWidth = W; inMemUnsigned = 0;
        inAluResult = 0; inWriteData = 0; inRegWrite = 0; inMemToReg = 0; inWriteReg = 0;

        //    rd wr  w  uns addr          data          rw stl rst
        drive(0, 0, W, 0, 32'h0,        32'h0,        0, 0, 1);
        drive(0, 0, W, 0, 32'h0,        32'h0,        0, 0, 1);
        check("rst_rdata", outReadData, 32'h0);

        drive(0, 1, W, 0, 32'h10,       32'h8899AABB, 0, 0, 0);
        drive(1, 0, W, 0, 32'h10,       32'h0,        1, 0, 0);
        check("lw10", outReadData, 32'h8899AABB);

        drive(0, 1, B, 0, 32'h13,       32'h000000F0, 0, 0, 0);
        drive(1, 0, B, 0, 32'h13,       32'h0,        1, 0, 0);
        check("lb13", outReadData, 32'hFFFFFFF0);
        drive(1, 0, B, 1, 32'h13,       32'h0,        1, 0, 0);
        check("lbu13", outReadData, 32'h000000F0);
        drive(1, 0, W, 0, 32'h10,       32'h0,        1, 0, 0);
        check("lw10_sb", outReadData, 32'hF099AABB);

        drive(0, 1, H, 0, 32'h22,       32'h00001234, 0, 0, 0);
        drive(1, 0, H, 0, 32'h22,       32'h0,        1, 0, 0);
        check("lh22", outReadData, 32'h00001234);
        drive(1, 0, W, 0, 32'h20,       32'h0,        1, 0, 0);
        check("lw20", outReadData, 32'h12340000);
        drive(0, 1, H, 0, 32'h24,       32'h00008001, 0, 0, 0);
        drive(1, 0, H, 0, 32'h24,       32'h0,        1, 0, 0);
        check("lh24", outReadData, 32'hFFFF8001);
        drive(1, 0, H, 1, 32'h24,       32'h0,        1, 0, 0);
        check("lhu24", outReadData, 32'h00008001);

        drive(1, 0, W, 0, 32'h11,       32'h0,        1, 0, 0);
        check("mis_err", 32'(outAddrError), 32'h1);
        check("mis_regw", 32'(outRegWrite), 32'h0);
        drive(0, 1, W, 0, 32'h11,       32'hDEADBEEF, 1, 0, 0);
        drive(0, 1, H, 0, 32'h13,       32'hDEADBEEF, 1, 0, 0);
        drive(1, 0, ILL, 0, 32'h10,     32'h0,        1, 0, 0);
        drive(1, 0, W, 0, 32'h10,       32'h0,        1, 0, 0);
        check("lw10_kept", outReadData, 32'hF099AABB);

        drive(0, 1, W, 0, 32'h30,       32'hCAFEF00D, 1, 1, 0);
        drive(0, 1, W, 0, 32'h30,       32'hCAFEF00D, 1, 1, 0);
        drive(0, 1, W, 0, 32'h30,       32'hCAFEF00D, 1, 1, 0);
        check("stall_hold", outReadData, 32'hF099AABB);
        drive(0, 1, W, 0, 32'h30,       32'hCAFEF00D, 1, 0, 0);
        drive(1, 0, W, 0, 32'h30,       32'h0,        1, 0, 0);
        check("lw30", outReadData, 32'hCAFEF00D);
        drive(0, 1, W, 0, 32'h34,       32'h55555555, 1, 1, 0);
        drive(0, 1, W, 0, 32'h34,       32'h55555555, 1, 1, 0);
        drive(0, 0, W, 0, 32'h34,       32'h0,        0, 0, 0);
        drive(1, 0, W, 0, 32'h34,       32'h0,        1, 0, 0);
        check("lw34_unwritten", outReadData, 32'h0);

        drive(1, 1, W, 0, 32'h50,       32'h00000005, 1, 0, 0);
        check("rdwr_rdata", outReadData, 32'h0);
        drive(1, 0, W, 0, 32'h50,       32'h0,        1, 0, 0);
        check("lw50", outReadData, 32'h5);
        drive(0, 0, W, 0, 32'h12345678, 32'hFFFFFFFF, 1, 0, 0);

        drive(0, 1, W, 0, 32'h40,       32'h77777777, 1, 1, 1);
        check("rst_stall_alu", outAluResult, 32'h0);
        drive(1, 0, W, 0, 32'h40,       32'h0,        1, 0, 0);
        check("lw40", outReadData, 32'h0);
        drive(0, 1, W, 0, 32'h400,      32'h11223344, 0, 0, 0);
        drive(1, 0, W, 0, 32'h0,        32'h0,        1, 0, 0);
        check("alias0", outReadData, 32'h11223344);
        drive(1, 0, B, 0, 32'h403,      32'h0,        1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
